debounce_scan_scheduler: RTL and testbench
==========================================

# debounce_scan_scheduler

Time-multiplexed debounce controller for the attitude indicator's front-panel buttons and switches. It shares one stability-counter update datapath among NUM_CH raw inputs. A prescaled sample tick triggers a round-robin scan, one channel per clock. Each confirmed level change is reported once as a press/release event on a valid/ready port that feeds the UI/mode-control logic.

## Interface
- NUM_CH, 4: number of input channels, 2..16.
- TICK_DIV, 500000: clock cycles per sample tick; must be ≥ NUM_CH+2.
- STABLE_TICKS, 10: consecutive differing samples needed to accept a new level; ≥1.

Ports:
- i_CLK  in  1  system clock.
- r_Reset  in  1  synchronous, active-high reset (reset r_Reset, synchronous, active-high; clock i_CLK).
- i_Bouncy  in  NUM_CH  raw asynchronous inputs.
- o_Debounced  out  NUM_CH  accepted level per channel.
- o_Event_Valid  out  1  event pending.
- o_Event_Ch  out  max(1,$clog2(NUM_CH))  channel index of the pending event.
- o_Event_Level  out  1  new level; 1 = press, 0 = release.
- i_Event_Ready  in  1  consumer accepts the event.
- o_Scan_Busy  out  1  FSM is not in IDLE.
- o_Overrun  out  1  sticky; a tick arrived while a scan was still in progress.

## Operation
- **Synchroniser:** 2-FF synchroniser per channel; its output is `sync`.
- **Prescaler:** counts 0..TICK_DIV-1 and wraps.
  - `tick` is high while the prescaler equals TICK_DIV-1.
- **Snapshot:** on `tick` in IDLE, `snap <= sync`, ch index is set to 0, and the FSM goes to SCAN.
- **Per-channel state:** count[ch], width $clog2(STABLE_TICKS+1).
- **FSM states:** IDLE, SCAN, HOLD.
- **SCAN, processing channel ch:**
  - snap[ch] == o_Debounced[ch]: count[ch] <= 0.
  - Differs and count[ch]+1 < STABLE_TICKS: count[ch] <= count[ch]+1.
  - Differs and count[ch]+1 == STABLE_TICKS (`flip`):
    - If the event slot is free, defined as `free = !o_Event_Valid || i_Event_Ready`: toggle o_Debounced[ch], set count[ch] <= 0, and load the event slot with {ch, snap[ch]}.
    - If the slot is not free: commit nothing, keep ch, and go to HOLD.
  - When a channel commits: if ch == NUM_CH-1 go to IDLE, else ch+1.
- **HOLD:** stays until `free`, then returns to SCAN on the same ch, which re-evaluates from the unchanged snap.
- **Event slot:** single register.
  - Cleared on valid && ready unless it is reloaded in the same cycle, so back-to-back events are allowed.
  - Ch and Level stay stable while Valid && !Ready.
- **Overrun:** a `tick` while in SCAN or HOLD sets o_Overrun and the tick is dropped; the prescaler keeps running. Only r_Reset clears o_Overrun.
- **Reset:** clears all outputs, counts, synchronisers, prescaler, snap and ch, and sends the FSM to IDLE. A reset during a scan aborts it and emits no event.

## Timing
- Reset values: o_Debounced=0, o_Event_Valid=0, o_Event_Ch=0, o_Event_Level=0, o_Scan_Busy=0, o_Overrun=0.
- Input to `sync`: 2 cycles.
- Tick at cycle T:
  - Snapshot taken at edge T; SCAN starts at T+1.
  - Without backpressure, channel k is processed in cycle T+1+k.
  - o_Debounced[k] and the event are visible from T+2+k.
  - IDLE is reached at T+1+NUM_CH.
- Minimum latency from a clean input edge to acceptance: 2 cycles + STABLE_TICKS ticks, plus up to one tick period of sampling phase.
- Each HOLD cycle adds one cycle of scan latency.

## Test plan
Common bench: NUM_CH=4, TICK_DIV=8, STABLE_TICKS=3, i_Event_Ready=1 unless stated.

- **Reset:** hold r_Reset for 3 cycles with i_Bouncy=4'hF -> all outputs 0; the first tick occurs 8 cycles after release.
- **Steady press:** drive i_Bouncy[2]=1 -> after the 3rd sampled tick, o_Debounced=4'b0100. Exactly one event {Ch=2, Level=1}, lasting one cycle. No further events.
- **Glitch:** ch1 high for 2 ticks, then low -> o_Debounced stays 0, no event, count[1] returns to 0.
  - Repeat with ch1 high for 3 ticks -> event {1,1}.
- **Simultaneous changes:** ch0 and ch3 rise together -> events {0,1} and {3,1} on cycles T+2 and T+5 of the accepting tick. o_Debounced=4'b1001.
- **Backpressure and overrun:** i_Event_Ready=0, ch0 and ch1 rise together -> event {0,1} is held.
  - FSM enters HOLD at ch1; o_Scan_Busy stays 1.
  - The next tick sets o_Overrun=1.
  - Raising Ready accepts {0,1}, then {1,1} follows, then IDLE.
- **Reset mid-scan:** assert r_Reset in the cycle after a tick whose scan includes a pending flip -> no event, o_Debounced=0, FSM IDLE, o_Overrun=0.

Source files
------------

// File: rtl/debounce_scan_scheduler.sv
// debounce_scan_scheduler: time-multiplexed debounce for front-panel inputs.
// One shared counter datapath scans NUM_CH channels round-robin per tick.
//
// Ports:
//   i_CLK, r_Reset       clock, synchronous active-high reset
//   i_Bouncy             raw asynchronous inputs
//   o_Debounced          accepted level per channel
//   o_Event_*            press/release event, valid/ready handshake
//   i_Event_Ready        consumer accepts the pending event
//   o_Scan_Busy          scan FSM not idle
//   o_Overrun            sticky: tick arrived mid-scan (tick dropped)
module debounce_scan_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 10,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_CLK,
  input  logic              r_Reset,
  input  logic [NUM_CH-1:0] i_Bouncy,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic              o_Event_Valid,
  output logic [CHW-1:0]    o_Event_Ch,
  output logic              o_Event_Level,
  input  logic              i_Event_Ready,
  output logic              o_Scan_Busy,
  output logic              o_Overrun
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]  TMAX = PW'(TICK_DIV - 1);
  localparam logic [CW:0]    ST   = (CW + 1)'(STABLE_TICKS);
  localparam logic [CHW-1:0] LAST = CHW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            r_State;
  state_t            w_Next;

  logic [NUM_CH-1:0] r_Sync1;
  logic [NUM_CH-1:0] r_Sync2;
  logic [NUM_CH-1:0] r_Snap;
  logic [PW-1:0]     r_Presc;
  logic [CW-1:0]     r_Count [NUM_CH];
  logic [CHW-1:0]    r_Ch;

  logic              w_Tick;
  logic              w_Free;
  logic              w_Differ;
  logic              w_Flip;
  logic [CW:0]       w_Cnt_Inc;
  logic              w_Snap_En;
  logic              w_Commit;
  logic              w_Load;

  assign w_Tick    = (r_Presc == TMAX);
  assign w_Free    = !o_Event_Valid || i_Event_Ready;
  assign w_Differ  = r_Snap[r_Ch] ^ o_Debounced[r_Ch];
  assign w_Cnt_Inc = {1'b0, r_Count[r_Ch]} + (CW + 1)'(1);
  assign w_Flip    = w_Differ && (w_Cnt_Inc == ST);

  // State register
  always_ff @(posedge i_CLK) begin
    if (r_Reset) r_State <= IDLE;
    else         r_State <= w_Next;
  end

  // Next-state logic
  always_comb begin
    w_Next = r_State;
    unique case (r_State)
      IDLE: if (w_Tick) w_Next = SCAN;
      SCAN: begin
        if (w_Flip && !w_Free) w_Next = HOLD;
        else if (r_Ch == LAST) w_Next = IDLE;
      end
      HOLD: if (w_Free) w_Next = SCAN;
      default: w_Next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    o_Scan_Busy = 1'b0;
    w_Snap_En   = 1'b0;
    w_Commit    = 1'b0;
    w_Load      = 1'b0;
    unique case (r_State)
      IDLE: w_Snap_En = w_Tick;
      SCAN: begin
        o_Scan_Busy = 1'b1;
        w_Commit    = !(w_Flip && !w_Free);
        w_Load      = w_Flip && w_Free;
      end
      HOLD: o_Scan_Busy = 1'b1;
      default: o_Scan_Busy = 1'b0;
    endcase
  end

  // Datapath
  always_ff @(posedge i_CLK) begin
    if (r_Reset) begin
      r_Sync1       <= '0;
      r_Sync2       <= '0;
      r_Snap        <= '0;
      r_Presc       <= '0;
      r_Ch          <= '0;
      o_Debounced   <= '0;
      o_Event_Valid <= 1'b0;
      o_Event_Ch    <= '0;
      o_Event_Level <= 1'b0;
      o_Overrun     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_Count[i] <= '0;
    end else begin
      r_Sync1 <= i_Bouncy;
      r_Sync2 <= r_Sync1;
      r_Presc <= w_Tick ? '0 : r_Presc + PW'(1);

      if (w_Tick && r_State != IDLE) o_Overrun <= 1'b1;

      if (w_Snap_En) begin
        r_Snap <= r_Sync2;
        r_Ch   <= '0;
      end

      if (w_Commit) begin
        if (r_Ch != LAST) r_Ch <= r_Ch + CHW'(1);
        if (!w_Differ) begin
          r_Count[r_Ch] <= '0;
        end else if (w_Flip) begin
          r_Count[r_Ch]     <= '0;
          o_Debounced[r_Ch] <= ~o_Debounced[r_Ch];
        end else begin
          r_Count[r_Ch] <= w_Cnt_Inc[CW-1:0];
        end
      end

      // A reload in the same cycle as a handshake keeps the slot full
      if (w_Load) begin
        o_Event_Valid <= 1'b1;
        o_Event_Ch    <= r_Ch;
        o_Event_Level <= r_Snap[r_Ch];
      end else if (o_Event_Valid && i_Event_Ready) begin
        o_Event_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// tb_debounce_scan_scheduler: directed + random bench for the debounce scan
// scheduler, compared cycle by cycle against a behavioural model.
module tb_debounce_scan_scheduler;

  localparam int NCH = 4;
  localparam int TD  = 8;
  localparam int ST  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bouncy = 4'hF;
  logic       ready = 1'b1;

  logic [3:0] o_Debounced;
  logic       o_Event_Valid;
  logic [1:0] o_Event_Ch;
  logic       o_Event_Level;
  logic       o_Scan_Busy;
  logic       o_Overrun;

  debounce_scan_scheduler #(
    .NUM_CH(NCH),
    .TICK_DIV(TD),
    .STABLE_TICKS(ST)
  ) dut (
    .i_CLK(clk),
    .r_Reset(rst),
    .i_Bouncy(bouncy),
    .o_Debounced(o_Debounced),
    .o_Event_Valid(o_Event_Valid),
    .o_Event_Ch(o_Event_Ch),
    .o_Event_Level(o_Event_Level),
    .i_Event_Ready(ready),
    .o_Scan_Busy(o_Scan_Busy),
    .o_Overrun(o_Overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: sync history, sample phase, scan position
  logic [3:0] m_s1 = '0, m_s2 = '0, m_snap = '0, m_deb = '0;
  int   m_phase = 0;
  int   m_cnt [NCH] = '{default: 0};
  int   m_pos = -1;
  bit   m_hold = 0;
  bit   m_valid = 0;
  int   m_ch = 0;
  bit   m_lvl = 0;
  bit   m_ovr = 0;

  int evq [$];
  int evt [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit free, tick, load;
    int c, nch;
    bit nlvl;
    load = 0; nch = 0; nlvl = 0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_snap = '0; m_deb = '0;
      m_phase = 0; m_pos = -1; m_hold = 0;
      m_valid = 0; m_ch = 0; m_lvl = 0; m_ovr = 0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      return;
    end
    free = !m_valid || ready;
    tick = (m_phase == TD - 1);
    if (m_pos < 0) begin
      if (tick) begin
        m_snap = m_s2;
        m_pos = 0;
      end
    end else begin
      if (tick) m_ovr = 1;
      if (m_hold) begin
        if (free) m_hold = 0;
      end else begin
        c = m_pos;
        if (m_snap[c] == m_deb[c]) begin
          m_cnt[c] = 0;
          m_pos = (c == NCH - 1) ? -1 : c + 1;
        end else if (m_cnt[c] + 1 < ST) begin
          m_cnt[c] = m_cnt[c] + 1;
          m_pos = (c == NCH - 1) ? -1 : c + 1;
        end else if (free) begin
          m_deb[c] = ~m_deb[c];
          m_cnt[c] = 0;
          load = 1; nch = c; nlvl = m_snap[c];
          m_pos = (c == NCH - 1) ? -1 : c + 1;
        end else begin
          m_hold = 1;
        end
      end
    end
    if (load) begin
      m_valid = 1; m_ch = nch; m_lvl = nlvl;
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    m_s2 = m_s1;
    m_s1 = bouncy;
    m_phase = (m_phase + 1) % TD;
  endtask

  function automatic bit flip_pending();
    for (int i = 0; i < NCH; i++)
      if (m_snap[i] != m_deb[i] && m_cnt[i] + 1 >= ST) return 1;
    return 0;
  endfunction

  task automatic cycle();
    if (!rst && o_Event_Valid === 1'b1 && ready) begin
      evq.push_back(int'({o_Event_Ch, o_Event_Level}));
      evt.push_back(cyc);
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("deb", o_Debounced, m_deb);
    chk("valid", o_Event_Valid, m_valid);
    chk("busy", o_Scan_Busy, m_pos >= 0);
    chk("ovr", o_Overrun, m_ovr);
    if (m_valid) begin
      chk("ev_ch", o_Event_Ch, m_ch);
      chk("ev_lvl", o_Event_Level, m_lvl);
    end
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset(logic [3:0] b);
    bouncy = b;
    rst = 1;
    run(3);
    rst = 0;
    evq.delete();
    evt.delete();
  endtask

  initial begin
    int n;
    bit found;
    logic [3:0] tgt;

    // Reset with all inputs high
    rst = 1; bouncy = 4'hF; ready = 1;
    run(3);
    chk("rst_deb", o_Debounced, 4'h0);
    chk("rst_valid", o_Event_Valid, 0);
    chk("rst_ch", o_Event_Ch, 0);
    chk("rst_lvl", o_Event_Level, 0);
    chk("rst_busy", o_Scan_Busy, 0);
    chk("rst_ovr", o_Overrun, 0);
    rst = 0;
    n = 0;
    while (!o_Scan_Busy && n < 20) begin
      cycle();
      n++;
    end
    chk("first_tick", n, 8);

    // Steady press on ch2
    do_reset(4'h0);
    bouncy = 4'b0100;
    run(40);
    chk("press_deb", o_Debounced, 4'b0100);
    chk("press_nev", evq.size(), 1);
    if (evq.size() > 0) chk("press_ev", evq[0], 5);

    // Glitch on ch1: two samples high, then a full three
    evq.delete();
    bouncy = 4'b0110;
    run(16);
    bouncy = 4'b0100;
    run(24);
    chk("glitch_deb", o_Debounced, 4'b0100);
    chk("glitch_nev", evq.size(), 0);
    bouncy = 4'b0110;
    run(40);
    chk("three_deb", o_Debounced, 4'b0110);
    chk("three_nev", evq.size(), 1);
    if (evq.size() > 0) chk("three_ev", evq[0], 3);

    // ch0 and ch3 rise together
    evq.delete(); evt.delete();
    bouncy = 4'hF;
    run(48);
    chk("simul_deb", o_Debounced, 4'hF);
    chk("simul_nev", evq.size(), 2);
    if (evq.size() == 2) begin
      chk("simul_ev0", evq[0], 1);
      chk("simul_ev1", evq[1], 7);
      chk("simul_gap", evt[1] - evt[0], 3);
    end

    // Backpressure and overrun
    do_reset(4'h0);
    ready = 0;
    bouncy = 4'b0011;
    run(40);
    chk("bp_valid", o_Event_Valid, 1);
    chk("bp_ch", o_Event_Ch, 0);
    chk("bp_lvl", o_Event_Level, 1);
    chk("bp_busy", o_Scan_Busy, 1);
    chk("bp_ovr", o_Overrun, 1);
    evq.delete();
    ready = 1;
    run(12);
    chk("bp_nev", evq.size(), 2);
    if (evq.size() == 2) begin
      chk("bp_ev0", evq[0], 1);
      chk("bp_ev1", evq[1], 3);
    end
    chk("bp_deb", o_Debounced, 4'b0011);

    // Reset in the cycle after a tick whose scan holds a flip
    bouncy = 4'b0100;
    found = 0;
    n = 0;
    while (!found && n < 200) begin
      cycle();
      n++;
      if (m_pos == 0 && flip_pending()) found = 1;
    end
    chk("mid_found", found, 1);
    evq.delete();
    rst = 1;
    run(1);
    chk("mid_deb", o_Debounced, 0);
    chk("mid_valid", o_Event_Valid, 0);
    chk("mid_busy", o_Scan_Busy, 0);
    chk("mid_ovr", o_Overrun, 0);
    rst = 0;
    run(8);
    chk("mid_nev", evq.size(), 0);

    // Random bouncing inputs with random backpressure
    tgt = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(59) == 0) tgt[c] = ~tgt[c];
        bouncy[c] = tgt[c] ^ ($urandom_range(9) == 0);
      end
      ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(1499) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
